gpio_int_bank: RTL

GPIO_INT_BANK -- requirements
Module: gpio_int_bank

---
 rtl/gpio_int_bank_if.sv | 28 ++
 rtl/gpio_int_bank.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/gpio_int_bank_if.sv
// Split read/write register bus for gpio_int_bank.
// The master drives strobes, addresses and write data; the slave returns read data and acks.
interface gpio_int_bank_if #(
  parameter int ADDR_BITS = 4
);
  logic                 WB_RD_STB_I;
  logic [ADDR_BITS-1:0] WB_RD_ADR_I;
  logic [31:0]          WB_RD_DAT_O;
  logic                 WB_RD_ACK_O;
  logic                 WB_WR_STB_I;
  logic                 WB_WR_WE_I;
  logic [3:0]           WB_WR_SEL_I;
  logic [ADDR_BITS-1:0] WB_WR_ADR_I;
  logic [31:0]          WB_WR_DAT_I;
  logic                 WB_WR_ACK_O;

  modport master (
    output WB_RD_STB_I, WB_RD_ADR_I, WB_WR_STB_I, WB_WR_WE_I,
           WB_WR_SEL_I, WB_WR_ADR_I, WB_WR_DAT_I,
    input  WB_RD_DAT_O, WB_RD_ACK_O, WB_WR_ACK_O
  );

  modport slave (
    input  WB_RD_STB_I, WB_RD_ADR_I, WB_WR_STB_I, WB_WR_WE_I,
           WB_WR_SEL_I, WB_WR_ADR_I, WB_WR_DAT_I,
    output WB_RD_DAT_O, WB_RD_ACK_O, WB_WR_ACK_O
  );
endinterface

// File: rtl/gpio_int_bank.sv
// GPIO bank with synchronised, prescaled glitch filtering and per-pin edge/level interrupts.
// Registers are reached through a split read/write bus with single-cycle acks.
module gpio_int_bank #(
  parameter int NUM_GPIOS    = 32,
  parameter int FILTER_DEPTH = 3,
  parameter int ADDR_BITS    = 4
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 sync_reset,
  gpio_int_bank_if.slave       wb,
  input  logic [NUM_GPIOS-1:0] gpio_in,
  output logic [NUM_GPIOS-1:0] gpio_out,
  output logic [NUM_GPIOS-1:0] gpio_oe,
  output logic                 int_gen
);

  typedef logic [NUM_GPIOS-1:0] gpio_t;

  localparam logic [ADDR_BITS-1:0] A_IN    = ADDR_BITS'(0);
  localparam logic [ADDR_BITS-1:0] A_OUT   = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] A_DIR   = ADDR_BITS'(2);
  localparam logic [ADDR_BITS-1:0] A_EN    = ADDR_BITS'(3);
  localparam logic [ADDR_BITS-1:0] A_TYPE  = ADDR_BITS'(4);
  localparam logic [ADDR_BITS-1:0] A_POL   = ADDR_BITS'(5);
  localparam logic [ADDR_BITS-1:0] A_BOTH  = ADDR_BITS'(6);
  localparam logic [ADDR_BITS-1:0] A_PEND  = ADDR_BITS'(7);
  localparam logic [ADDR_BITS-1:0] A_PRESC = ADDR_BITS'(8);

  function automatic logic [31:0] lane_mask(input logic [3:0] sel);
    return {{8{sel[3]}}, {8{sel[2]}}, {8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [31:0] merge_lanes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [31:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  gpio_t out_q, out_d, dir_q, dir_d, en_q, en_d;
  gpio_t type_q, type_d, pol_q, pol_d, both_q, both_d, pend_q, pend_d;
  gpio_t sync1_q, sync2_q, filt_q, filt_d, filt_prev_q;
  gpio_t clr_s, rise_s, fall_s, edge_s, lvl_s, set_s;
  logic [NUM_GPIOS-1:0][FILTER_DEPTH-1:0] hist_q, hist_d;
  logic [15:0] presc_q, presc_d, cnt_q, cnt_d;
  logic [31:0] mask_s, rd_mux_s, rd_dat_q, rd_dat_d;
  logic        wr_en_s, presc_wr_s, tick_s;
  logic        rd_ack_q, wr_ack_q, int_q, int_d;

  assign wr_en_s = wb.WB_WR_STB_I & wb.WB_WR_WE_I;
  assign mask_s  = lane_mask(wb.WB_WR_SEL_I);

  // Byte-lane register writes, W1C clear mask and prescale restart request.
  always_comb begin
    out_d      = out_q;
    dir_d      = dir_q;
    en_d       = en_q;
    type_d     = type_q;
    pol_d      = pol_q;
    both_d     = both_q;
    presc_d    = presc_q;
    clr_s      = '0;
    presc_wr_s = 1'b0;
    if (wr_en_s) begin
      case (wb.WB_WR_ADR_I)
        A_OUT:   out_d  = gpio_t'(merge_lanes(32'(out_q),  wb.WB_WR_DAT_I, mask_s));
        A_DIR:   dir_d  = gpio_t'(merge_lanes(32'(dir_q),  wb.WB_WR_DAT_I, mask_s));
        A_EN:    en_d   = gpio_t'(merge_lanes(32'(en_q),   wb.WB_WR_DAT_I, mask_s));
        A_TYPE:  type_d = gpio_t'(merge_lanes(32'(type_q), wb.WB_WR_DAT_I, mask_s));
        A_POL:   pol_d  = gpio_t'(merge_lanes(32'(pol_q),  wb.WB_WR_DAT_I, mask_s));
        A_BOTH:  both_d = gpio_t'(merge_lanes(32'(both_q), wb.WB_WR_DAT_I, mask_s));
        A_PEND:  clr_s  = gpio_t'(wb.WB_WR_DAT_I & mask_s);
        A_PRESC: begin
          presc_d    = 16'(merge_lanes(32'(presc_q), wb.WB_WR_DAT_I, mask_s));
          presc_wr_s = 1'b1;
        end
        default: clr_s = '0;
      endcase
    end else begin
      clr_s = '0;
    end
  end

  // Prescale tick and per-pin history filter; a level is accepted only once the history agrees.
  always_comb begin
    logic [FILTER_DEPTH-1:0] h;
    tick_s = (cnt_q == presc_q);
    if (presc_wr_s || tick_s) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
    hist_d = hist_q;
    filt_d = filt_q;
    for (int i = 0; i < NUM_GPIOS; i++) begin
      h = {hist_q[i][FILTER_DEPTH-2:0], sync2_q[i]};
      if (tick_s) begin
        hist_d[i] = h;
        if (&h) begin
          filt_d[i] = 1'b1;
        end else if (~|h) begin
          filt_d[i] = 1'b0;
        end else begin
          filt_d[i] = filt_q[i];
        end
      end else begin
        hist_d[i] = hist_q[i];
      end
    end
  end

  // Interrupt sources; a new set wins over a simultaneous W1C of the same bit.
  always_comb begin
    rise_s = filt_q & ~filt_prev_q;
    fall_s = ~filt_q & filt_prev_q;
    edge_s = (both_q & (rise_s | fall_s)) | (~both_q & ((pol_q & fall_s) | (~pol_q & rise_s)));
    lvl_s  = (pol_q & ~filt_q) | (~pol_q & filt_q);
    set_s  = (type_q & lvl_s) | (~type_q & edge_s);
    pend_d = (pend_q & ~clr_s) | set_s;
    int_d  = |(pend_q & en_q);
  end

  // Read data multiplexer; unmapped space and unimplemented bits read as zero.
  always_comb begin
    case (wb.WB_RD_ADR_I)
      A_IN:    rd_mux_s = 32'(filt_q);
      A_OUT:   rd_mux_s = 32'(out_q);
      A_DIR:   rd_mux_s = 32'(dir_q);
      A_EN:    rd_mux_s = 32'(en_q);
      A_TYPE:  rd_mux_s = 32'(type_q);
      A_POL:   rd_mux_s = 32'(pol_q);
      A_BOTH:  rd_mux_s = 32'(both_q);
      A_PEND:  rd_mux_s = 32'(pend_q);
      A_PRESC: rd_mux_s = {16'd0, presc_q};
      default: rd_mux_s = 32'd0;
    endcase
    if (wb.WB_RD_STB_I) begin
      rd_dat_d = rd_mux_s;
    end else begin
      rd_dat_d = 32'd0;
    end
  end

  // State registers with asynchronous and synchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_q <= '0; dir_q <= '0; en_q <= '0; type_q <= '0; pol_q <= '0; both_q <= '0;
      pend_q <= '0; presc_q <= 16'd0; cnt_q <= 16'd0;
      sync1_q <= '0; sync2_q <= '0; hist_q <= '0; filt_q <= '0; filt_prev_q <= '0;
      rd_dat_q <= 32'd0; rd_ack_q <= 1'b0; wr_ack_q <= 1'b0; int_q <= 1'b0;
    end else if (sync_reset) begin
      out_q <= '0; dir_q <= '0; en_q <= '0; type_q <= '0; pol_q <= '0; both_q <= '0;
      pend_q <= '0; presc_q <= 16'd0; cnt_q <= 16'd0;
      sync1_q <= '0; sync2_q <= '0; hist_q <= '0; filt_q <= '0; filt_prev_q <= '0;
      rd_dat_q <= 32'd0; rd_ack_q <= 1'b0; wr_ack_q <= 1'b0; int_q <= 1'b0;
    end else begin
      out_q <= out_d; dir_q <= dir_d; en_q <= en_d; type_q <= type_d; pol_q <= pol_d; both_q <= both_d;
      pend_q <= pend_d; presc_q <= presc_d; cnt_q <= cnt_d;
      sync1_q <= gpio_in; sync2_q <= sync1_q; hist_q <= hist_d; filt_q <= filt_d; filt_prev_q <= filt_q;
      rd_dat_q <= rd_dat_d; rd_ack_q <= wb.WB_RD_STB_I; wr_ack_q <= wr_en_s; int_q <= int_d;
    end
  end

  assign gpio_out       = out_q;
  assign gpio_oe        = dir_q;
  assign int_gen        = int_q;
  assign wb.WB_RD_DAT_O = rd_dat_q;
  assign wb.WB_RD_ACK_O = rd_ack_q;
  assign wb.WB_WR_ACK_O = wr_ack_q;

endmodule
